// File: rtl/median_filter_pkg.sv
// Types and constants shared by the median filter datapath and its frame source.
package median_filter_pkg;

    localparam int unsigned PIXEL_W = 8;

    typedef struct packed {
        logic [PIXEL_W-1:0] r;
        logic [PIXEL_W-1:0] g;
        logic [PIXEL_W-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } streamer_state_t;

endpackage

// File: rtl/pixel_valid_if.sv
// Valid-only pixel stream; the slave has no backpressure.
interface pixel_valid_if;
    import median_filter_pkg::*;

    logic   valid;
    pixel_t pixel;

    modport master (output valid, output pixel);
    modport slave  (input valid, input pixel);

endinterface

// File: rtl/stream_pacer.sv
// Pace counter: allows one memory read every PIXEL_PERIOD cycles while enabled,
// with hold suppressing a read only once the pace count has expired.
module stream_pacer #(
    parameter int unsigned PIXEL_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold_i,
    output logic issue
);

    localparam int unsigned PACE_W = (PIXEL_PERIOD > 1) ? $clog2(PIXEL_PERIOD) : 1;

    logic [PACE_W-1:0] pace_q, pace_d;

    // Issue strobe: pace expired and not throttled.
    always_comb begin
        issue = en && (pace_q == '0) && !hold_i;
    end

    // Reload on issue, count down otherwise; held at 0 outside STREAM so a new frame
    // starts with an immediate read.
    always_comb begin
        pace_d = pace_q;
        if (!en) begin
            pace_d = '0;
        end else if (issue) begin
            pace_d = PACE_W'(PIXEL_PERIOD - 1);
        end else if (pace_q != '0) begin
            pace_d = pace_q - PACE_W'(1);
        end
    end

    // Pace counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pace_q <= '0;
        end else begin
            pace_q <= pace_d;
        end
    end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Reads one frame from a synchronous-read frame memory in raster order and streams it
// out as a paced valid-only pixel stream, flagging row ends and the frame end.
module pixel_frame_streamer
    import median_filter_pkg::*;
#(
    parameter int unsigned IMAGE_LEN    = 1080,
    parameter int unsigned IMAGE_HEIGHT = 720,
    parameter int unsigned PIXEL_PERIOD = 2,
    localparam int unsigned ADDR_W      = $clog2(IMAGE_LEN * IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  pixel_t            mem_rd_data_i,
    pixel_valid_if.master     pixel_valid_if_o,
    output logic              eol_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned NPIX  = IMAGE_LEN * IMAGE_HEIGHT;
    localparam int unsigned COL_W = $clog2(IMAGE_LEN);

    streamer_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;

    // Stage 1: read in flight (memory data valid this cycle).
    logic rd_valid_q, rd_valid_d;
    logic rd_eol_q, rd_eol_d;
    logic rd_last_q, rd_last_d;

    // Stage 2: output register.
    logic   valid_q, valid_d;
    pixel_t pixel_q, pixel_d;
    logic   eol_q, eol_d;
    logic   done_q, done_d;

    logic issue;
    logic last_addr;
    logic last_col;

    stream_pacer #(
        .PIXEL_PERIOD (PIXEL_PERIOD)
    ) u_pacer (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == StStream),
        .hold_i (hold_i),
        .issue  (issue)
    );

    assign last_addr = (addr_q == ADDR_W'(NPIX - 1));
    assign last_col  = (col_q == COL_W'(IMAGE_LEN - 1));

    // FSM and address/column counters; counters only advance on an issued read.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StStream;
                    addr_d  = '0;
                    col_d   = '0;
                end
            end
            StStream: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    col_d  = last_col ? '0 : col_q + COL_W'(1);
                    if (last_addr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave as the final pixel is presented.
                if (done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Valid/eol/last flags travel alongside the read; pixel holds when no data arrives.
    always_comb begin
        rd_valid_d = issue;
        rd_eol_d   = issue && last_col;
        rd_last_d  = issue && last_addr;
        valid_d    = rd_valid_q;
        eol_d      = rd_eol_q;
        done_d     = rd_last_q;
        pixel_d    = rd_valid_q ? mem_rd_data_i : pixel_q;
    end

    // State, counters and pipeline registers; reset aborts any reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            col_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_eol_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
            eol_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            rd_valid_q <= rd_valid_d;
            rd_eol_q   <= rd_eol_d;
            rd_last_q  <= rd_last_d;
            valid_q    <= valid_d;
            pixel_q    <= pixel_d;
            eol_q      <= eol_d;
            done_q     <= done_d;
        end
    end

    assign mem_rd_en_o            = issue;
    assign mem_rd_addr_o          = addr_q;
    assign pixel_valid_if_o.valid = valid_q;
    assign pixel_valid_if_o.pixel = pixel_q;
    assign eol_o                  = eol_q;
    assign done_o                 = done_q;
    assign busy_o                 = (state_q != StIdle);

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Two 4x3 streamers (PIXEL_PERIOD 1 and 2) share one stimulus timeline; a frame-level
// reference model fills per-DUT scoreboards and per-cycle expectations before the run.
module tb_pixel_frame_streamer;
    import median_filter_pkg::*;

    localparam int unsigned LEN   = 4;
    localparam int unsigned HGT   = 3;
    localparam int unsigned NPIX  = LEN * HGT;
    localparam int unsigned AW    = $clog2(NPIX);
    localparam int          TOTAL = 570;
    localparam int          NSCN  = 6;

    typedef struct {
        int     cyc;
        pixel_t pix;
        bit     eol;
        bit     done;
    } exp_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic hold_i = 1'b0;

    logic          rd_en0, rd_en1, eol0, eol1, busy0, busy1, done0, done1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    pixel_t        rd_data0 = '0;
    pixel_t        rd_data1 = '0;

    pixel_valid_if pif0 ();
    pixel_valid_if pif1 ();

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    bit     sched_rst   [TOTAL];
    bit     sched_start [TOTAL];
    bit     sched_hold  [TOTAL];
    pixel_t mem_tab     [NSCN][16];

    bit exp_busy [2][TOTAL];
    bit exp_rd   [2][TOTAL];
    int exp_addr [2][TOTAL];
    exp_item_t exp_q0[$];
    exp_item_t exp_q1[$];

    bit act_valid [2][TOTAL];
    bit act_done  [2][TOTAL];
    bit act_rd    [2][TOTAL];
    bit act_eol   [2][TOTAL];
    bit act_busy  [2][TOTAL];

    pixel_frame_streamer #(
        .IMAGE_LEN    (LEN),
        .IMAGE_HEIGHT (HGT),
        .PIXEL_PERIOD (1)
    ) u_dut0 (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .hold_i           (hold_i),
        .mem_rd_en_o      (rd_en0),
        .mem_rd_addr_o    (rd_addr0),
        .mem_rd_data_i    (rd_data0),
        .pixel_valid_if_o (pif0),
        .eol_o            (eol0),
        .busy_o           (busy0),
        .done_o           (done0)
    );

    pixel_frame_streamer #(
        .IMAGE_LEN    (LEN),
        .IMAGE_HEIGHT (HGT),
        .PIXEL_PERIOD (2)
    ) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .hold_i           (hold_i),
        .mem_rd_en_o      (rd_en1),
        .mem_rd_addr_o    (rd_addr1),
        .mem_rd_data_i    (rd_data1),
        .pixel_valid_if_o (pif1),
        .eol_o            (eol1),
        .busy_o           (busy1),
        .done_o           (done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int scn_of(input int c);
        int s;
        if (c < 10) return 0;
        s = (c - 10) / 60;
        return (s > NSCN - 1) ? NSCN - 1 : s;
    endfunction

    // Synchronous-read frame memories, one per DUT.
    always @(posedge clk) begin
        if (rd_en0) rd_data0 <= mem_tab[scn_of(cyc)][rd_addr0];
        if (rd_en1) rd_data1 <= mem_tab[scn_of(cyc)][rd_addr1];
    end

    function automatic void chk(input string name, input int w, input longint act,
                                input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=0x%0h expected=0x%0h",
                     name, w, cyc, act, exp);
        end
    endfunction

    function automatic int q_size(input int w);
        if (w == 0) return exp_q0.size();
        return exp_q1.size();
    endfunction

    function automatic exp_item_t q_front(input int w);
        if (w == 0) return exp_q0[0];
        return exp_q1[0];
    endfunction

    function automatic void q_pop(input int w);
        if (w == 0) void'(exp_q0.pop_front());
        else void'(exp_q1.pop_front());
    endfunction

    // Frame-level model: accepted starts, read times from pace/hold rules, reset truncation.
    task automatic build_model(input int w, input int p);
        int        next_free;
        int        reads [NPIX];
        int        t, r, done_c;
        exp_item_t it;
        next_free = 0;
        for (int c = 0; c < TOTAL; c++) begin
            if (sched_rst[c]) begin
                next_free = c + 1;
                continue;
            end
            if (!sched_start[c] || c < next_free) continue;
            t = c + 1;
            for (int k = 0; k < int'(NPIX); k++) begin
                while (t < TOTAL && sched_hold[t]) t++;
                reads[k] = t;
                t += p;
            end
            done_c = reads[NPIX-1] + 2;
            r = 1 << 30;
            for (int x = c + 1; x <= done_c && x < TOTAL; x++) begin
                if (sched_rst[x]) begin
                    r = x;
                    break;
                end
            end
            for (int x = c + 1; x <= done_c && x <= r && x < TOTAL; x++) exp_busy[w][x] = 1'b1;
            for (int k = 0; k < int'(NPIX); k++) begin
                if (reads[k] <= r && reads[k] < TOTAL) begin
                    exp_rd[w][reads[k]]   = 1'b1;
                    exp_addr[w][reads[k]] = k;
                end
                if (reads[k] + 2 <= r && reads[k] + 2 < TOTAL) begin
                    it.cyc  = reads[k] + 2;
                    it.pix  = mem_tab[scn_of(reads[k])][k];
                    it.eol  = ((k % LEN) == LEN - 1);
                    it.done = (k == int'(NPIX) - 1);
                    if (w == 0) exp_q0.push_back(it);
                    else exp_q1.push_back(it);
                end
            end
            next_free = (r <= done_c) ? r + 1 : done_c + 1;
        end
    endtask

    task automatic mon(input int w, input logic v, input pixel_t px, input logic e,
                       input logic d, input logic b, input logic re, input logic [AW-1:0] a);
        exp_item_t it;
        bit        have;
        while (q_size(w) > 0) begin
            it = q_front(w);
            if (it.cyc >= cyc) break;
            chk("valid_missed", w, 0, 1);
            q_pop(w);
        end
        have = (q_size(w) > 0) && (it.cyc == cyc);
        chk("valid", w, v, have);
        if (have) begin
            if (v) begin
                chk("pixel", w, px, it.pix);
                chk("eol", w, e, it.eol);
                chk("done", w, d, it.done);
            end
            q_pop(w);
        end else begin
            chk("done_without_valid", w, d, 0);
        end
        chk("busy", w, b, exp_busy[w][cyc]);
        chk("rd_en", w, re, exp_rd[w][cyc]);
        if (re && exp_rd[w][cyc]) chk("rd_addr", w, a, exp_addr[w][cyc]);
        if (cyc == 1 || cyc == 198) begin
            chk("rst_pixel", w, px, 0);
            chk("rst_addr", w, a, 0);
            chk("rst_eol", w, e, 0);
        end
        act_valid[w][cyc] = v;
        act_done[w][cyc]  = d;
        act_rd[w][cyc]    = re;
        act_eol[w][cyc]   = e;
        act_busy[w][cyc]  = b;
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < TOTAL) begin
            mon(0, pif0.valid, pif0.pixel, eol0, done0, busy0, rd_en0, rd_addr0);
            mon(1, pif1.valid, pif1.pixel, eol1, done1, busy1, rd_en1, rd_addr1);
        end
    end

    // Input driver: applies the schedule just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < TOTAL) begin
                rst     = sched_rst[cyc];
                start_i = sched_start[cyc];
                hold_i  = sched_hold[cyc];
            end else begin
                rst     = 1'b0;
                start_i = 1'b0;
                hold_i  = 1'b0;
            end
        end
    end

    function automatic int cnt(input int kind, input int w, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            case (kind)
                0: n += int'(act_valid[w][c]);
                1: n += int'(act_done[w][c]);
                2: n += int'(act_rd[w][c]);
                default: n += int'(act_eol[w][c]);
            endcase
        end
        return n;
    endfunction

    function automatic int cnt_pairs(input int w, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c < hi; c++) n += int'(act_valid[w][c] && act_valid[w][c+1]);
        return n;
    endfunction

    initial begin
        int b;
        for (int c = 0; c < 3; c++) sched_rst[c] = 1'b1;
        for (int a = 0; a < 16; a++) begin
            mem_tab[0][a] = '{r: 8'(a), g: 8'(a), b: 8'(a)};
            for (int s = 1; s < NSCN; s++) mem_tab[s][a] = pixel_t'($urandom);
        end
        for (int i = 0; i < 5; i++) begin
            b = 10 + 60 * i;
            if (i > 0) sched_rst[b-2] = 1'b1;
            sched_start[b] = 1'b1;
        end
        sched_start[76] = 1'b1;
        for (int c = 135; c <= 138; c++) sched_hold[c] = 1'b1;
        sched_rst[197]   = 1'b1;
        sched_start[202] = 1'b1;
        for (int c = 250; c <= 290; c++) sched_start[c] = 1'b1;
        sched_rst[308] = 1'b1;
        for (int c = 310; c < 550; c++) begin
            sched_start[c] = ($urandom_range(7) == 0);
            sched_hold[c]  = ($urandom_range(3) == 0);
            sched_rst[c]   = ($urandom_range(63) == 0);
        end
        sched_rst[550] = 1'b1;

        build_model(0, 1);
        build_model(1, 2);

        while (cyc < TOTAL) @(posedge clk);

        // Single frame, period 1 and 2.
        chk("s1_no_early_valid", 0, act_valid[0][12], 0);
        chk("s1_first_valid", 0, act_valid[0][13], 1);
        chk("s1_valid_count", 0, cnt(0, 0, 13, 24), 12);
        chk("s1_done_at_14", 0, act_done[0][24], 1);
        chk("s1_done_count", 0, cnt(1, 0, 10, 67), 1);
        chk("s1_eol_px3", 0, act_eol[0][16], 1);
        chk("s1_eol_px7", 0, act_eol[0][20], 1);
        chk("s1_eol_count", 0, cnt(3, 0, 10, 67), 3);
        chk("s1_busy_before", 0, act_busy[0][10], 0);
        chk("s1_busy_first", 0, act_busy[0][11], 1);
        chk("s1_busy_last", 0, act_busy[0][24], 1);
        chk("s1_busy_after", 0, act_busy[0][25], 0);
        chk("s1p2_done_at_25", 1, act_done[1][35], 1);
        chk("s1p2_valid_count", 1, cnt(0, 1, 10, 67), 12);
        chk("s1p2_no_adjacent", 1, cnt_pairs(1, 10, 67), 0);
        chk("s1p2_gap", 1, act_valid[1][14], 0);
        // Restart ignored while busy.
        chk("s2_done_at_14", 0, act_done[0][84], 1);
        chk("s2_valid_count", 0, cnt(0, 0, 70, 127), 12);
        chk("s2_done_count", 0, cnt(1, 0, 70, 127), 1);
        // Hold throttle.
        chk("s3_no_reads", 0, cnt(2, 0, 135, 138), 0);
        chk("s3_no_valid", 0, cnt(0, 0, 137, 140), 0);
        chk("s3_done_at_18", 0, act_done[0][148], 1);
        chk("s3_valid_count", 0, cnt(0, 0, 130, 187), 12);
        // Mid-frame reset then restart.
        chk("s4_busy_after_rst", 0, act_busy[0][198], 0);
        chk("s4_quiet_after_rst", 0, cnt(0, 0, 198, 204), 0);
        chk("s4_restart_valid", 0, act_valid[0][205], 1);
        chk("s4_restart_done", 0, act_done[0][216], 1);
        // Start held high: back-to-back frames.
        chk("s5_idle_gap", 0, act_rd[0][265], 0);
        chk("s5_second_read", 0, act_rd[0][266], 1);
        chk("s5_done2", 0, act_done[0][279], 1);
        chk("s5_done3", 0, act_done[0][294], 1);
        chk("s5_done_count", 0, cnt(1, 0, 250, 307), 3);
        chk("leftover_expected", 0, exp_q0.size(), 0);
        chk("leftover_expected", 1, exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
